msrv32_machine_control: RTL and testbench
=========================================

# msrv32_machine_control

Machine-mode trap sequencer for the msrv32 core. Watches decoded-instruction exception flags, SYSTEM instructions (ECALL/EBREAK/MRET) and the interrupt enable/pending bits exported by the CSR file. Drives the CSR file's trap-side controls (set_epc, set_cause, cause, i_or_e, mie_clear/mie_set, instret_inc) and the PC-mux select and pipeline flush. Sits directly upstream of the CSR file and beside the PC mux.

## Interface
Parameters: none.
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on rising edge
- ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-high
- illegal_instr_in  input  1  decoder flags an illegal instruction
- misaligned_instr_in  input  1  target fetch address not 4-byte aligned
- misaligned_load_in  input  1  load address misaligned
- misaligned_store_in  input  1  store address misaligned
- opcode_6_to_2_in  input  5  instr[6:2]
- funct3_in  input  3  instr[14:12]
- funct7_in  input  7  instr[31:25]
- rs1_addr_in  input  5  instr[19:15]
- rs2_addr_in  input  5  instr[24:20]
- rd_addr_in  input  5  instr[11:7]
- mie_in  input  1  mstatus.MIE from the CSR file
- meie_in, mtie_in, msie_in  input  1 each  mie register enable bits
- meip_in, mtip_in, msip_in  input  1 each  mip pending bits
- i_or_e_out  output  1  1 = interrupt, 0 = exception; to CSR file
- cause_out  output  4  mcause code; to CSR file
- set_cause_out  output  1  load mcause
- set_epc_out  output  1  load mepc from the PC
- mie_clear_out  output  1  save and clear mstatus.MIE
- mie_set_out  output  1  restore mstatus.MIE (MRET)
- instret_inc_out  output  1  retire one instruction
- misaligned_exception_out  output  1  misaligned trap in progress; suppresses the memory write
- pc_src_out  output  2  00 boot, 01 mepc, 10 trap vector, 11 sequential/branch
- flush_out  output  1  squash the instruction in the pipeline register

## Operation
- State register, 2 bits: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
- Decode, all with opcode_6_to_2_in = 5'b11100, funct3_in = 0, rs1 = 0, rd = 0:
  - ECALL: {funct7,rs2} = 12'h000
  - EBREAK: {funct7,rs2} = 12'h001
  - MRET: {funct7,rs2} = 12'h302
- irq_pend = mie_in & ((meie_in&meip_in) | (msie_in&msip_in) | (mtie_in&mtip_in)).
- exc_pend = illegal | misaligned_* | ECALL | EBREAK.
- Transitions:
  - RESET -> OPERATING unconditionally.
  - OPERATING -> TRAP_TAKEN if irq_pend or exc_pend.
  - Else OPERATING -> TRAP_RETURN if MRET.
  - Else OPERATING stays in OPERATING.
  - TRAP_TAKEN -> OPERATING.
  - TRAP_RETURN -> OPERATING.
- Cause priority is fixed, highest first. Interrupts beat exceptions.
  - Interrupts (i_or_e = 1): external 11, software 3, timer 7.
  - Exceptions (i_or_e = 0): misaligned instr 0, illegal 2, EBREAK 3, ECALL 11, misaligned load 4, misaligned store 6.
- cause_out and i_or_e_out are registered on the OPERATING -> TRAP_TAKEN edge. They hold until the next trap entry.
- Moore outputs:
  - RESET: pc_src = 00, flush = 1, all pulses 0.
  - OPERATING: pc_src = 11, instret_inc = 1 unless leaving to TRAP_TAKEN or TRAP_RETURN this cycle.
  - TRAP_TAKEN: set_epc = set_cause = mie_clear = 1, pc_src = 10, flush = 1.
  - TRAP_RETURN: mie_set = 1, pc_src = 01, flush = 1.
- misaligned_exception_out = 1 combinationally in OPERATING while any misaligned_* input is high and no interrupt wins.

## Timing
- Reset values:
  - state = RESET, pc_src = 00, flush = 1.
  - cause = 0, i_or_e = 0.
  - All pulse outputs 0.
  - Reset asserted mid-trap overrides the state on the next edge.
- The first OPERATING cycle is 1 clock after reset is released.
- Trap entry: the cycle after the condition is seen in OPERATING, TRAP_TAKEN is active for exactly 1 cycle. The CSR file latches mepc/mcause at the end of that cycle. OPERATING resumes 2 cycles after detection.
- MRET: TRAP_RETURN is active for exactly 1 cycle, then OPERATING.
- An interrupt arriving during TRAP_TAKEN or TRAP_RETURN is not sampled. It is re-evaluated in OPERATING. mie_clear guarantees it is masked after a trap entry.
- MRET with a simultaneous irq_pend: the trap wins; MRET is not executed.
- Pending inputs are level-sensitive; there is no edge detection.

## Configuration
- MSRV32_MISALIGNED_TRAP_EN defined:
  - The three misaligned inputs raise exceptions with causes 0, 4 and 6.
  - misaligned_exception_out is functional.
- Not defined:
  - The misaligned inputs are ignored.
  - misaligned_exception_out is tied to 0.
  - Causes 0, 4 and 6 are never produced.

## Test plan
- Reset: hold rst for 2 cycles -> pc_src 00, flush 1, all pulses 0. Release -> pc_src 11 and instret_inc 1 on the next cycle.
- ECALL (opcode 11100, all other fields 0) in OPERATING -> next cycle:
  - set_epc = set_cause = mie_clear = 1, cause 4'hB, i_or_e 0, pc_src 10, flush 1.
  - Following cycle back to OPERATING.
- mie_in = 1, meie = meip = 1, mtie = mtip = 1, with illegal_instr high -> cause 11, i_or_e 1 (external beats timer and the exception).
- MRET ({funct7,rs2} = 12'h302) -> 1 cycle of mie_set = 1, pc_src 01, flush 1, instret_inc 0.
- mie_in = 0 with all enable and pending bits 1 -> stays in OPERATING, no trap pulses, instret_inc 1 every cycle.
- misaligned_store_in = 1:
  - With MSRV32_MISALIGNED_TRAP_EN: misaligned_exception_out 1, then cause 6.
  - Without it: no trap, misaligned_exception_out 0.

Source files
------------

// File: rtl/msrv32_machine_control_if.sv
// Trap-control bundle between the machine-mode sequencer (master) and the
// decoder/CSR-file/PC-mux side (slave).
interface msrv32_machine_control_if;
    logic       illegal_instr_in;
    logic       misaligned_instr_in;
    logic       misaligned_load_in;
    logic       misaligned_store_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs1_addr_in;
    logic [4:0] rs2_addr_in;
    logic [4:0] rd_addr_in;
    logic       mie_in;
    logic       meie_in;
    logic       mtie_in;
    logic       msie_in;
    logic       meip_in;
    logic       mtip_in;
    logic       msip_in;

    logic       i_or_e_out;
    logic [3:0] cause_out;
    logic       set_cause_out;
    logic       set_epc_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic       instret_inc_out;
    logic       misaligned_exception_out;
    logic [1:0] pc_src_out;
    logic       flush_out;

    modport master (
        input  illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
        input  opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
        input  mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
        output i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
        output instret_inc_out, misaligned_exception_out, pc_src_out, flush_out
    );

    modport slave (
        output illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
        output opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
        output mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
        input  i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
        input  instret_inc_out, misaligned_exception_out, pc_src_out, flush_out
    );
endinterface

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap sequencer: picks trap cause, drives CSR trap controls, PC select and flush.
// Define MSRV32_MISALIGNED_TRAP_EN to make the misaligned instr/load/store inputs raise traps.
module msrv32_machine_control (
    input logic ms_riscv32_mp_clk_in,
    input logic ms_riscv32_mp_rst_in,
    msrv32_machine_control_if.master mc
);
    typedef enum logic [1:0] {
        RESET       = 2'b00,
        OPERATING   = 2'b01,
        TRAP_TAKEN  = 2'b10,
        TRAP_RETURN = 2'b11
    } state_t;

    state_t     state, next_state;
    logic       sys_base, is_ecall, is_ebreak, is_mret;
    logic       irq_ext, irq_sw, irq_tmr, irq_pend, exc_pend, trap_req;
    logic       mis_instr, mis_load, mis_store, mis_any;
    logic [3:0] cause_nxt, cause_q;
    logic       ioe_nxt, ioe_q;

    assign sys_base  = (mc.opcode_6_to_2_in == 5'b11100) && (mc.funct3_in == 3'd0) &&
                       (mc.rs1_addr_in == 5'd0) && (mc.rd_addr_in == 5'd0);
    assign is_ecall  = sys_base && ({mc.funct7_in, mc.rs2_addr_in} == 12'h000);
    assign is_ebreak = sys_base && ({mc.funct7_in, mc.rs2_addr_in} == 12'h001);
    assign is_mret   = sys_base && ({mc.funct7_in, mc.rs2_addr_in} == 12'h302);

`ifdef MSRV32_MISALIGNED_TRAP_EN
    assign mis_instr = mc.misaligned_instr_in;
    assign mis_load  = mc.misaligned_load_in;
    assign mis_store = mc.misaligned_store_in;
`else
    logic unused_misaligned;
    assign unused_misaligned = ^{mc.misaligned_instr_in, mc.misaligned_load_in, mc.misaligned_store_in};
    assign mis_instr = 1'b0;
    assign mis_load  = 1'b0;
    assign mis_store = 1'b0;
`endif
    assign mis_any = mis_instr | mis_load | mis_store;

    assign irq_ext  = mc.mie_in & mc.meie_in & mc.meip_in;
    assign irq_sw   = mc.mie_in & mc.msie_in & mc.msip_in;
    assign irq_tmr  = mc.mie_in & mc.mtie_in & mc.mtip_in;
    assign irq_pend = irq_ext | irq_sw | irq_tmr;
    assign exc_pend = mc.illegal_instr_in | mis_any | is_ecall | is_ebreak;
    assign trap_req = irq_pend | exc_pend;

    // Fixed priority: interrupts first, then exceptions in architectural order
    always_comb begin
        cause_nxt = 4'd0;
        ioe_nxt   = 1'b0;
        if (irq_ext) begin
            cause_nxt = 4'd11; ioe_nxt = 1'b1;
        end else if (irq_sw) begin
            cause_nxt = 4'd3;  ioe_nxt = 1'b1;
        end else if (irq_tmr) begin
            cause_nxt = 4'd7;  ioe_nxt = 1'b1;
        end else if (mis_instr) begin
            cause_nxt = 4'd0;
        end else if (mc.illegal_instr_in) begin
            cause_nxt = 4'd2;
        end else if (is_ebreak) begin
            cause_nxt = 4'd3;
        end else if (is_ecall) begin
            cause_nxt = 4'd11;
        end else if (mis_load) begin
            cause_nxt = 4'd4;
        end else if (mis_store) begin
            cause_nxt = 4'd6;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state   <= RESET;
            cause_q <= 4'd0;
            ioe_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == OPERATING && trap_req) begin
                cause_q <= cause_nxt;
                ioe_q   <= ioe_nxt;
            end
        end
    end

    always_comb begin
        next_state = OPERATING;
        case (state)
            RESET:       next_state = OPERATING;
            OPERATING: begin
                if (trap_req)     next_state = TRAP_TAKEN;
                else if (is_mret) next_state = TRAP_RETURN;
                else              next_state = OPERATING;
            end
            TRAP_TAKEN:  next_state = OPERATING;
            TRAP_RETURN: next_state = OPERATING;
            default:     next_state = RESET;
        endcase
    end

    always_comb begin
        mc.pc_src_out               = 2'b11;
        mc.flush_out                = 1'b0;
        mc.set_epc_out              = 1'b0;
        mc.set_cause_out            = 1'b0;
        mc.mie_clear_out            = 1'b0;
        mc.mie_set_out              = 1'b0;
        mc.instret_inc_out          = 1'b0;
        mc.misaligned_exception_out = 1'b0;
        case (state)
            RESET: begin
                mc.pc_src_out = 2'b00;
                mc.flush_out  = 1'b1;
            end
            OPERATING: begin
                mc.instret_inc_out          = ~(trap_req | is_mret);
                mc.misaligned_exception_out = mis_any & ~irq_pend;
            end
            TRAP_TAKEN: begin
                mc.pc_src_out    = 2'b10;
                mc.flush_out     = 1'b1;
                mc.set_epc_out   = 1'b1;
                mc.set_cause_out = 1'b1;
                mc.mie_clear_out = 1'b1;
            end
            TRAP_RETURN: begin
                mc.pc_src_out  = 2'b01;
                mc.flush_out   = 1'b1;
                mc.mie_set_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign mc.cause_out  = cause_q;
    assign mc.i_or_e_out = ioe_q;
endmodule

// File: tb/tb_msrv32_machine_control.sv
// Scoreboard bench for msrv32_machine_control: directed per-cycle vectors, negedge monitor.
module tb_msrv32_machine_control;
    typedef struct packed {
        logic [1:0] pc_src;
        logic       flush;
        logic       set_epc;
        logic       set_cause;
        logic       mie_clear;
        logic       mie_set;
        logic       instret;
        logic       mis;
        logic [3:0] cause;
        logic       ioe;
    } exp_t;

`ifdef MSRV32_MISALIGNED_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t  exp_q[$];
    string nm_q[$];

    msrv32_machine_control_if bus ();

    msrv32_machine_control dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .mc(bus.master)
    );

    always #5 clk = ~clk;

    function automatic exp_t e_rst();
        exp_t e = '0;
        e.pc_src = 2'b00; e.flush = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_op(input logic inst, input logic mis, input logic [3:0] c, input logic ioe);
        exp_t e = '0;
        e.pc_src = 2'b11; e.instret = inst; e.mis = mis; e.cause = c; e.ioe = ioe;
        return e;
    endfunction

    function automatic exp_t e_tt(input logic [3:0] c, input logic ioe);
        exp_t e = '0;
        e.pc_src = 2'b10; e.flush = 1'b1; e.set_epc = 1'b1; e.set_cause = 1'b1;
        e.mie_clear = 1'b1; e.cause = c; e.ioe = ioe;
        return e;
    endfunction

    function automatic exp_t e_tr(input logic [3:0] c, input logic ioe);
        exp_t e = '0;
        e.pc_src = 2'b01; e.flush = 1'b1; e.mie_set = 1'b1; e.cause = c; e.ioe = ioe;
        return e;
    endfunction

    task automatic idle_in();
        bus.illegal_instr_in = 0; bus.misaligned_instr_in = 0;
        bus.misaligned_load_in = 0; bus.misaligned_store_in = 0;
        bus.opcode_6_to_2_in = 5'b01100; bus.funct3_in = 0; bus.funct7_in = 0;
        bus.rs1_addr_in = 0; bus.rs2_addr_in = 0; bus.rd_addr_in = 0;
        bus.mie_in = 0; bus.meie_in = 0; bus.mtie_in = 0; bus.msie_in = 0;
        bus.meip_in = 0; bus.mtip_in = 0; bus.msip_in = 0;
    endtask

    task automatic sys_in(input logic [11:0] imm);
        bus.opcode_6_to_2_in = 5'b11100;
        bus.funct7_in = imm[11:5];
        bus.rs2_addr_in = imm[4:0];
    endtask

    task automatic step(input string nm, input exp_t e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares one expected vector per cycle at the falling edge
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                a.pc_src    = bus.pc_src_out;
                a.flush     = bus.flush_out;
                a.set_epc   = bus.set_epc_out;
                a.set_cause = bus.set_cause_out;
                a.mie_clear = bus.mie_clear_out;
                a.mie_set   = bus.mie_set_out;
                a.instret   = bus.instret_inc_out;
                a.mis       = bus.misaligned_exception_out;
                a.cause     = bus.cause_out;
                a.ioe       = bus.i_or_e_out;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got pc=%b fl=%b epc=%b sc=%b mc=%b ms=%b ir=%b mis=%b cause=%0d ioe=%b, want pc=%b fl=%b epc=%b sc=%b mc=%b ms=%b ir=%b mis=%b cause=%0d ioe=%b",
                             nm, a.pc_src, a.flush, a.set_epc, a.set_cause, a.mie_clear, a.mie_set,
                             a.instret, a.mis, a.cause, a.ioe, e.pc_src, e.flush, e.set_epc,
                             e.set_cause, e.mie_clear, e.mie_set, e.instret, e.mis, e.cause, e.ioe);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        rst = 1'b1;
        @(posedge clk);
        #1;

        step("reset_hold0", e_rst());
        step("reset_hold1", e_rst());
        rst = 1'b0;
        step("reset_release", e_rst());
        step("first_operating", e_op(1, 0, 4'd0, 0));

        sys_in(12'h000);
        step("ecall_detect", e_op(0, 0, 4'd0, 0));
        idle_in();
        step("ecall_trap", e_tt(4'd11, 0));
        step("ecall_resume", e_op(1, 0, 4'd11, 0));

        bus.mie_in = 1; bus.meie_in = 1; bus.meip_in = 1; bus.mtie_in = 1; bus.mtip_in = 1;
        bus.illegal_instr_in = 1;
        step("ext_irq_detect", e_op(0, 0, 4'd11, 0));
        idle_in();
        step("ext_irq_trap", e_tt(4'd11, 1));
        step("ext_irq_resume", e_op(1, 0, 4'd11, 1));

        sys_in(12'h302);
        step("mret_detect", e_op(0, 0, 4'd11, 1));
        idle_in();
        step("mret_return", e_tr(4'd11, 1));
        step("mret_resume", e_op(1, 0, 4'd11, 1));

        bus.meie_in = 1; bus.mtie_in = 1; bus.msie_in = 1;
        bus.meip_in = 1; bus.mtip_in = 1; bus.msip_in = 1;
        for (int i = 0; i < 3; i++) step("mie_masked", e_op(1, 0, 4'd11, 1));

        // MRET loses to software+timer irq; irq held through TRAP_TAKEN is not resampled
        bus.meie_in = 0; bus.meip_in = 0; bus.mie_in = 1;
        sys_in(12'h302);
        step("mret_vs_irq_detect", e_op(0, 0, 4'd11, 1));
        step("mret_vs_irq_trap", e_tt(4'd3, 1));
        idle_in();
        step("mret_vs_irq_resume", e_op(1, 0, 4'd3, 1));

        sys_in(12'h001);
        bus.illegal_instr_in = 1;
        step("illegal_vs_ebreak_detect", e_op(0, 0, 4'd3, 1));
        idle_in();
        step("illegal_vs_ebreak_trap", e_tt(4'd2, 0));

        sys_in(12'h001);
        step("ebreak_detect", e_op(0, 0, 4'd2, 0));
        idle_in();
        step("ebreak_trap", e_tt(4'd3, 0));
        step("ebreak_resume", e_op(1, 0, 4'd3, 0));

        bus.misaligned_store_in = 1;
        if (MIS_EN) begin
            step("mis_store_detect", e_op(0, 1, 4'd3, 0));
            idle_in();
            step("mis_store_trap", e_tt(4'd6, 0));
            step("mis_store_resume", e_op(1, 0, 4'd6, 0));
        end else begin
            step("mis_store_ignored", e_op(1, 0, 4'd3, 0));
            idle_in();
            step("mis_store_ignored_next", e_op(1, 0, 4'd3, 0));
            step("mis_store_ignored_idle", e_op(1, 0, 4'd3, 0));
        end

        bus.misaligned_load_in = 1;
        bus.mie_in = 1; bus.mtie_in = 1; bus.mtip_in = 1;
        step("timer_vs_mis_load_detect", e_op(0, 0, MIS_EN ? 4'd6 : 4'd3, 0));
        idle_in();
        step("timer_vs_mis_load_trap", e_tt(4'd7, 1));
        step("timer_resume", e_op(1, 0, 4'd7, 1));

        sys_in(12'h000);
        step("ecall2_detect", e_op(0, 0, 4'd7, 1));
        idle_in();
        rst = 1'b1;
        step("reset_mid_trap", e_tt(4'd11, 0));
        step("reset_after_trap", e_rst());
        rst = 1'b0;
        step("reset_release2", e_rst());
        step("operating_again", e_op(1, 0, 4'd0, 0));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
